npc_sequencer: RTL and testbench

Control sequencer for the PC/nPC pair of the SPARC datapath. Owns the PC and nPC registers, drives the next-PC adders (+4/+8), runs a request/acknowledge handshake with instruction fetch, and applies SPARC delayed-branch, annul and trap redirection from execute-stage resolution. Sits between fetch and the branch/trap logic in the execute stage.

---
 rtl/npc_sequencer.sv | 118 +++++++++++
 tb/tb_npc_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_sequencer.sv
// npc_sequencer: owns the SPARC PC/nPC pair, handshakes with fetch, and
// applies delayed-branch, annul and trap redirection from execute.
module npc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  output logic        inst_valid,
  input  logic        ctrl_valid,
  input  logic        br_taken,
  input  logic        br_always,
  input  logic        br_annul,
  input  logic [31:0] br_target,
  input  logic        trap,
  input  logic [31:0] trap_vec,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        trap_ack,
  output logic [15:0] retire_cnt,
  output logic [15:0] annul_cnt
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_TRAP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [15:0] retire_q, retire_d;
  logic [15:0] annul_q, annul_d;

  // Word-aligned redirect addresses; the low two bits are don't-care inputs.
  logic [31:0] target_w;
  logic [31:0] vec_w;
  assign target_w = br_target & ~32'h3;
  assign vec_w    = trap_vec  & ~32'h3;

  // Next-state and next-PC selection; rules are tested in priority order.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    retire_d = retire_q;
    annul_d  = annul_q;
    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        if (fetch_ack) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (ctrl_valid) begin
          state_d = ST_FETCH;
          if (trap) begin
            // Trap overrides any branch resolved in the same cycle.
            state_d = ST_TRAP;
            pc_d    = vec_w;
            npc_d   = vec_w + 32'd4;
          end else if (br_always && br_taken && br_annul) begin
            // ba,a: the delay slot is skipped and control goes straight to target.
            pc_d     = target_w;
            npc_d    = target_w + 32'd4;
            annul_d  = annul_q + 16'd1;
            retire_d = retire_q + 16'd1;
          end else if (br_taken) begin
            // Delayed branch: execute the slot at nPC, then the target.
            pc_d     = npc_q;
            npc_d    = target_w;
            retire_d = retire_q + 16'd1;
          end else if (br_annul) begin
            // Untaken annulling branch: skip the delay slot.
            pc_d     = npc_q + 32'd4;
            npc_d    = npc_q + 32'd8;
            annul_d  = annul_q + 16'd1;
            retire_d = retire_q + 16'd1;
          end else begin
            pc_d     = npc_q;
            npc_d    = npc_q + 32'd4;
            retire_d = retire_q + 16'd1;
          end
        end
      end
      ST_TRAP: state_d = ST_FETCH;
      default: state_d = ST_RESET;
    endcase
  end

  // State, PC pair and counters; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RESET;
      pc_q     <= RESET_PC;
      npc_q    <= RESET_PC + 32'd4;
      retire_q <= 16'd0;
      annul_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      retire_q <= retire_d;
      annul_q  <= annul_d;
    end
  end

  assign fetch_req  = (state_q == ST_FETCH);
  assign inst_valid = (state_q == ST_EXEC);
  assign trap_ack   = (state_q == ST_TRAP);
  assign fetch_addr = pc_q;
  assign pc         = pc_q;
  assign npc        = npc_q;
  assign retire_cnt = retire_q;
  assign annul_cnt  = annul_q;

endmodule

// File: tb/tb_npc_sequencer.sv
// Scoreboard bench for npc_sequencer: a driver issues fetch acks and
// resolutions and queues the expected results; a monitor checks them.
module tb_npc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack = 1'b0;
  logic        inst_valid;
  logic        ctrl_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        br_always = 1'b0;
  logic        br_annul = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        trap = 1'b0;
  logic [31:0] trap_vec = 32'h0;
  logic [31:0] pc, npc;
  logic        trap_ack;
  logic [15:0] retire_cnt, annul_cnt;

  npc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .inst_valid(inst_valid), .ctrl_valid(ctrl_valid),
    .br_taken(br_taken), .br_always(br_always), .br_annul(br_annul),
    .br_target(br_target), .trap(trap), .trap_vec(trap_vec),
    .pc(pc), .npc(npc), .trap_ack(trap_ack),
    .retire_cnt(retire_cnt), .annul_cnt(annul_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [15:0] ret;
    logic [15:0] ann;
    logic        is_trap;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  int vecs = 0;
  int miscompares = 0;

  // Reference architectural state
  logic [31:0] m_pc, m_npc;
  logic [15:0] m_ret, m_ann;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    vecs++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Monitor: compares whenever the DUT completes a resolution or raises a fetch.
  initial begin
    logic prev_iv, prev_fr, prev_ta;
    logic [31:0] prev_addr;
    exp_t e;
    logic [31:0] a;
    prev_iv = 0; prev_fr = 0; prev_ta = 0; prev_addr = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        prev_iv = 0; prev_fr = 0; prev_ta = 0;
        continue;
      end
      if (prev_iv && !inst_valid) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_resolution");
        end else begin
          e = exp_q.pop_front();
          chk("res_pc", pc, e.pc);
          chk("res_npc", npc, e.npc);
          chk("res_retire", {16'h0, retire_cnt}, {16'h0, e.ret});
          chk("res_annul", {16'h0, annul_cnt}, {16'h0, e.ann});
          chk("res_trap_ack", {31'h0, trap_ack}, {31'h0, e.is_trap});
          chk("res_fetch_req", {31'h0, fetch_req}, {31'h0, !e.is_trap});
        end
      end
      if (prev_ta) begin
        chk("trap_ack_width", {31'h0, trap_ack}, 32'h0);
        chk("post_trap_fetch_req", {31'h0, fetch_req}, 32'h1);
      end
      if (fetch_req && !prev_fr) begin
        if (addr_q.size() == 0) begin
          timeout("unexpected_fetch");
        end else begin
          a = addr_q.pop_front();
          chk("fetch_addr", fetch_addr, a);
        end
      end else if (fetch_req && prev_fr) begin
        chk("fetch_addr_stable", fetch_addr, prev_addr);
      end
      prev_iv = inst_valid;
      prev_fr = fetch_req;
      prev_ta = trap_ack;
      prev_addr = fetch_addr;
    end
  end

  // Asynchronous reset mid-cycle, with a stray fetch_ack held during reset.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_pc = 32'h0; m_npc = 32'h4; m_ret = 16'h0; m_ann = 16'h0;
    exp_q.delete();
    addr_q.delete();
    addr_q.push_back(32'h0);
    #1;
    chk("rst_fetch_req", {31'h0, fetch_req}, 32'h0);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_trap_ack", {31'h0, trap_ack}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_npc", npc, 32'h4);
    chk("rst_retire", {16'h0, retire_cnt}, 32'h0);
    chk("rst_annul", {16'h0, annul_cnt}, 32'h0);
    fetch_ack = 1'b1;
    ctrl_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_inst_valid", {31'h0, inst_valid}, 32'h0);
    end
    fetch_ack = 1'b0;
    rst_n = 1'b1;
  endtask

  // One full fetch/execute transaction with the given resolution inputs.
  task automatic run_instr(input bit tr, input bit al, input bit tk, input bit an,
                           input logic [31:0] tgt, input logic [31:0] tv);
    int n;
    exp_t e;
    logic [31:0] t, v;
    n = 0;
    while (fetch_req !== 1'b1) begin
      if (n == 20) begin timeout("wait_fetch_req"); return; end
      @(negedge clk); n++;
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    fetch_ack = 1'b1;
    ctrl_valid = 1'($urandom);
    trap = 1'($urandom);
    br_taken = 1'($urandom);
    @(negedge clk);
    fetch_ack = 1'b0;
    ctrl_valid = 1'b0;
    n = 0;
    while (inst_valid !== 1'b1) begin
      if (n == 20) begin timeout("wait_inst_valid"); return; end
      @(negedge clk); n++;
    end
    repeat ($urandom_range(0, 2)) begin
      fetch_ack = 1'($urandom);
      trap = 1'($urandom);
      br_taken = 1'($urandom);
      br_target = $urandom;
      @(negedge clk);
    end
    fetch_ack = 1'b0;
    ctrl_valid = 1'b1;
    trap = tr; br_always = al; br_taken = tk; br_annul = an;
    br_target = tgt; trap_vec = tv;
    t = {tgt[31:2], 2'b00};
    v = {tv[31:2], 2'b00};
    if (tr) begin
      m_pc = v; m_npc = v + 4;
    end else if (al && tk && an) begin
      m_pc = t; m_npc = t + 4; m_ann++; m_ret++;
    end else if (tk) begin
      m_pc = m_npc; m_npc = t; m_ret++;
    end else if (an) begin
      m_pc = m_npc + 4; m_npc = m_npc + 8; m_ann++; m_ret++;
    end else begin
      m_pc = m_npc; m_npc = m_npc + 4; m_ret++;
    end
    e.pc = m_pc; e.npc = m_npc; e.ret = m_ret; e.ann = m_ann; e.is_trap = tr;
    exp_q.push_back(e);
    addr_q.push_back(m_pc);
    @(negedge clk);
    ctrl_valid = 1'b0; trap = 1'b0; br_always = 1'b0; br_taken = 1'b0; br_annul = 1'b0;
  endtask

  task automatic plain();
    run_instr(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic chk_state(input logic [31:0] epc, input logic [31:0] enpc,
                           input logic [15:0] eret, input logic [15:0] eann);
    chk("dir_pc", pc, epc);
    chk("dir_npc", npc, enpc);
    chk("dir_retire", {16'h0, retire_cnt}, {16'h0, eret});
    chk("dir_annul", {16'h0, annul_cnt}, {16'h0, eann});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Sequential run
    do_reset();
    plain(); plain(); plain();
    chk_state(32'hC, 32'h10, 16'd3, 16'd0);
    // Delayed branch
    do_reset();
    plain(); plain();
    run_instr(0, 0, 1, 0, 32'h100, 32'h0);
    chk_state(32'hC, 32'h100, 16'd3, 16'd0);
    plain();
    chk_state(32'h100, 32'h104, 16'd4, 16'd0);
    // Annulled untaken
    do_reset();
    plain(); plain();
    run_instr(0, 0, 0, 1, 32'h0, 32'h0);
    chk_state(32'h10, 32'h14, 16'd3, 16'd1);
    // ba,a with misaligned target
    do_reset();
    plain(); plain();
    run_instr(0, 1, 1, 1, 32'h203, 32'h0);
    chk_state(32'h200, 32'h204, 16'd3, 16'd1);
    // Trap beats a taken branch
    do_reset();
    plain(); plain();
    run_instr(1, 0, 1, 0, 32'h100, 32'h80);
    chk_state(32'h80, 32'h84, 16'd2, 16'd0);
    plain();
    chk_state(32'h84, 32'h88, 16'd3, 16'd0);
    // 32-bit wrap of the PC pair
    do_reset();
    run_instr(0, 1, 1, 1, 32'hFFFF_FFF8, 32'h0);
    plain();
    chk_state(32'hFFFF_FFFC, 32'h0, 16'd2, 16'd1);
    plain();
    chk_state(32'h0, 32'h4, 16'd3, 16'd1);
    // Reset while fetching at pc=0x40
    do_reset();
    plain();
    run_instr(0, 1, 1, 1, 32'h40, 32'h0);
    chk("pre_reset_fetch_req", {31'h0, fetch_req}, 32'h1);
    chk("pre_reset_pc", pc, 32'h40);
    do_reset();
    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] tg;
      tg = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      run_instr($urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom), 1'($urandom), tg, $urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    repeat (4) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 32'h0);
    chk("addr_queue_drained", addr_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
